// File: rtl/ac_dec_pkg.sv
// ac_dec_pkg
// Shared definitions for the arithmetic-decoder renormalization slice:
// default widths, FSM state codes, reset/re-init constants and the helper
// that computes the refill shift position from the bit count.
package ac_dec_pkg;

    localparam int WIN_DEF   = 32;
    localparam int RNG_W_DEF = 16;
    localparam int CNT_W_DEF = 8;

    // FSM state codes
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REFILL = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;
    localparam logic [1:0] ST_RENORM = 2'd3;

    // Re-init values. DIF_INIT is given for the default window; the top
    // derives the same pattern (0 followed by all ones) for its own WIN.
    localparam logic [RNG_W_DEF-1:0] RNG_INIT = 16'h8000;
    localparam logic [WIN_DEF-1:0]   DIF_INIT = {1'b0, {(WIN_DEF-1){1'b1}}};
    localparam int                   CNT_INIT = -15;

    // Bit position at which the next byte is XORed into dif:
    // s = WIN-9-(cnt+15). A negative result means the window is full.
    function automatic int refill_shift(input int win, input int cnt);
        return win - 24 - cnt;
    endfunction

endpackage

// File: rtl/ac_dec_lzc16.sv
// ac_dec_lzc16
// Combinational 16-bit leading-zero counter.
// Ports:
//   value    in  16  word to examine
//   count    out 4   number of leading zeros (15 when value is zero)
//   all_zero out 1   value is entirely zero
module ac_dec_lzc16 (
    input  logic [15:0] value,
    output logic [3:0]  count,
    output logic        all_zero
);

    // Scan upward so the highest set bit is the last one to write count.
    always_comb begin
        count    = 4'd15;
        all_zero = (value == 16'h0000);
        for (int i = 0; i < 16; i++) begin
            if (value[i]) begin
                count = 4'(15 - i);
            end
        end
    end

endmodule

// File: rtl/ac_dec_renorm.sv
// ac_dec_renorm
// Range/window renormalization and byte refill stage of the arithmetic
// decoder. Holds rng, the dif window and the signed bit count cnt, presents
// rng and the top 16 bits of dif to the symbol logic, accepts one update per
// symbol, renormalizes, then refills dif one byte per cycle.
// Ports:
//   clk, reset (async, active low)
//   start                         re-initialize for a new stream
//   upd_valid/upd_ready           symbol update handshake
//   upd_rng, upd_dif_sub          new range and dif subtrahend
//   byte_valid/byte_ready         bitstream byte handshake
//   byte_data                     bitstream byte
//   stream_end                    no more bytes, feed zeros
//   rng_out, dif_top, state_valid decoder state presented downstream
//   tail_bytes                    zero bytes inserted after stream_end
module ac_dec_renorm
    import ac_dec_pkg::*;
#(
    parameter int WIN   = WIN_DEF,
    parameter int RNG_W = RNG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [RNG_W-1:0] upd_rng,
    input  logic [15:0]      upd_dif_sub,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic [7:0]       byte_data,
    input  logic             stream_end,
    output logic [RNG_W-1:0] rng_out,
    output logic [15:0]      dif_top,
    output logic             state_valid,
    output logic [7:0]       tail_bytes
);

    localparam int               SH_W      = $clog2(WIN);
    localparam logic [WIN-1:0]   DIF_RESET = {1'b0, {(WIN-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_RESET = CNT_W'(CNT_INIT);

    logic [1:0]       state;
    logic [RNG_W-1:0] rng;
    logic [WIN-1:0]   dif;
    logic [CNT_W-1:0] cnt;

    int               s_val;
    logic             need_byte;
    logic [SH_W-1:0]  shamt;
    logic [WIN-1:0]   byte_shifted;
    logic [WIN-1:0]   sub_shifted;
    logic [3:0]       lz;
    logic             lz_zero;
    logic [RNG_W-1:0] rng_renorm;
    logic [WIN-1:0]   dif_inc;
    logic [WIN-1:0]   dif_renorm;
    logic [CNT_W-1:0] cnt_renorm;

    ac_dec_lzc16 u_lzc (
        .value    (rng),
        .count    (lz),
        .all_zero (lz_zero)
    );

    // Refill position and the operands for the refill, update and renorm
    // datapaths. Renorm shifts ones in at the bottom of dif, hence +1/-1.
    always_comb begin
        s_val        = refill_shift(WIN, int'($signed(cnt)));
        need_byte    = (s_val >= 0);
        shamt        = s_val[SH_W-1:0];
        byte_shifted = {{(WIN-8){1'b0}}, byte_data} << shamt;
        sub_shifted  = {upd_dif_sub, {(WIN-16){1'b0}}};
        rng_renorm   = lz_zero ? '0 : (rng << lz);
        dif_inc      = dif + WIN'(1);
        dif_renorm   = (dif_inc << lz) - WIN'(1);
        cnt_renorm   = cnt - CNT_W'(lz);
    end

    // A byte is only requested when a real one is wanted; start abandons the
    // refill, so no handshake may complete in that cycle.
    always_comb begin
        state_valid = (state == ST_READY);
        upd_ready   = state_valid;
        byte_ready  = (state == ST_REFILL) && need_byte && !stream_end && !start;
        rng_out     = rng;
        dif_top     = dif[WIN-1 -: 16];
    end

    // Main FSM. start re-initializes from any state and wins over updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            rng        <= RNG_INIT;
            dif        <= DIF_RESET;
            cnt        <= CNT_RESET;
            tail_bytes <= 8'd0;
        end else if (start) begin
            state      <= ST_REFILL;
            rng        <= RNG_INIT;
            dif        <= DIF_RESET;
            cnt        <= CNT_RESET;
            tail_bytes <= 8'd0;
        end else begin
            case (state)
                ST_REFILL: begin
                    if (!need_byte) begin
                        state <= ST_READY;
                    end else if (stream_end) begin
                        cnt <= cnt + CNT_W'(8);
                        if (tail_bytes != 8'hFF) begin
                            tail_bytes <= tail_bytes + 8'd1;
                        end
                    end else if (byte_valid) begin
                        dif <= dif ^ byte_shifted;
                        cnt <= cnt + CNT_W'(8);
                    end
                end
                ST_READY: begin
                    if (upd_valid) begin
                        dif   <= dif - sub_shifted;
                        rng   <= upd_rng;
                        state <= ST_RENORM;
                    end
                end
                ST_RENORM: begin
                    rng   <= rng_renorm;
                    dif   <= dif_renorm;
                    cnt   <= cnt_renorm;
                    state <= cnt_renorm[CNT_W-1] ? ST_REFILL : ST_READY;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ac_dec_renorm.sv
// tb_ac_dec_renorm
// Self-checking bench for ac_dec_renorm: directed scenarios plus randomized
// updates compared against an arithmetic model of the decoder state.
module tb_ac_dec_renorm;

    logic        clk;
    logic        reset;
    logic        start;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_rng;
    logic [15:0] upd_dif_sub;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        stream_end;
    logic [15:0] rng_out;
    logic [15:0] dif_top;
    logic        state_valid;
    logic [7:0]  tail_bytes;

    int vectors     = 0;
    int miscompares = 0;

    // Model state
    longint m_dif;
    int     m_rng;
    int     m_cnt;
    int     m_tail;
    int     m_taken;
    int     mq[$];
    logic [7:0] src[$];

    ac_dec_renorm dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_rng     (upd_rng),
        .upd_dif_sub (upd_dif_sub),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .byte_data   (byte_data),
        .stream_end  (stream_end),
        .rng_out     (rng_out),
        .dif_top     (dif_top),
        .state_valid (state_valid),
        .tail_bytes  (tail_bytes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    task automatic m_init();
        m_rng  = 32'h8000;
        m_dif  = 64'h7FFF_FFFF;
        m_cnt  = -15;
        m_tail = 0;
    endtask

    task automatic m_refill(input bit se);
        int s;
        int b;
        while (8 - m_cnt >= 0) begin
            s = 8 - m_cnt;
            if (se) begin
                b = 0;
                if (m_tail < 255) m_tail++;
            end else begin
                b = mq.pop_front();
                m_taken++;
            end
            m_dif = (m_dif ^ (longint'(b) << s)) & 64'hFFFF_FFFF;
            m_cnt += 8;
        end
    endtask

    task automatic m_update(input int r, input int sub, input bit se);
        int d;
        m_dif = (m_dif - (longint'(sub) << 16)) & 64'hFFFF_FFFF;
        d = 0;
        while (r < 32'h8000 && d < 15) begin
            r = r * 2;
            d++;
        end
        m_rng = r & 32'hFFFF;
        m_dif = (((m_dif + 1) << d) - 1) & 64'hFFFF_FFFF;
        m_cnt -= d;
        if (m_cnt < 0) m_refill(se);
    endtask

    // ---------------- drivers ----------------
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_update(input logic [15:0] r, input logic [15:0] sub);
        upd_valid   = 1'b1;
        upd_rng     = r;
        upd_dif_sub = sub;
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    // Steps the clock offering bytes from src until state_valid or budget.
    // stall: number of cycles byte_ready is left unanswered before offering.
    task automatic run_until_valid(input int budget, input int stall,
                                   output int hs, output int cycles, output bit done);
        int st;
        bit hs_now;
        st = stall;
        hs = 0;
        cycles = 0;
        while (state_valid !== 1'b1 && cycles < budget) begin
            byte_valid = (st == 0) && (src.size() > 0);
            byte_data  = (src.size() > 0) ? src[0] : 8'h00;
            #2;
            hs_now = byte_valid && byte_ready;
            if (byte_ready === 1'b1 && st > 0) st--;
            @(posedge clk); #1;
            cycles++;
            if (hs_now) begin
                void'(src.pop_front());
                hs++;
            end
        end
        byte_valid = 1'b0;
        done = (state_valid === 1'b1);
    endtask

    task automatic establish_base();
        int hs, cyc;
        bit done;
        src.delete(); mq.delete();
        src.push_back(8'h12); src.push_back(8'h34); src.push_back(8'h56);
        mq.push_back(8'h12);  mq.push_back(8'h34);  mq.push_back(8'h56);
        m_init();
        m_refill(1'b0);
        do_start();
        run_until_valid(20, 0, hs, cyc, done);
        vectors++;
        if (!done) begin
            miscompares++;
            $display("[TB] FAIL base_timeout state_valid=%b required=1", state_valid);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        #12;
        vectors++;
        if (rng_out !== 16'h8000 || dif_top !== 16'h7FFF || state_valid !== 1'b0 ||
            upd_ready !== 1'b0 || byte_ready !== 1'b0 || tail_bytes !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_values rng=%h dif_top=%h sv=%b ur=%b br=%b tail=%0d required 8000/7fff/0/0/0/0",
                     rng_out, dif_top, state_valid, upd_ready, byte_ready, tail_bytes);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        // IDLE ignores updates
        do_update(16'h1234, 16'h0000);
        @(posedge clk); #1;
        vectors++;
        if (rng_out !== 16'h8000 || state_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_ignores_update rng=%h sv=%b required 8000/0", rng_out, state_valid);
        end
    endtask

    task automatic test_start_refill();
        int hs, cyc;
        bit done;
        src.delete(); mq.delete();
        src.push_back(8'h12); src.push_back(8'h34); src.push_back(8'h56);
        mq.push_back(8'h12);  mq.push_back(8'h34);  mq.push_back(8'h56);
        m_init();
        m_taken = 0;
        m_refill(1'b0);
        do_start();
        run_until_valid(20, 0, hs, cyc, done);
        vectors++;
        if (hs != 3 || cyc != 4) begin
            miscompares++;
            $display("[TB] FAIL start_handshakes hs=%0d cycles=%0d required 3/4", hs, cyc);
        end
        vectors++;
        if (dut.dif !== 32'h76E5D4FF || dif_top !== 16'h76E5 || dut.dif !== m_dif[31:0]) begin
            miscompares++;
            $display("[TB] FAIL start_dif dif=%h dif_top=%h required 76e5d4ff/76e5", dut.dif, dif_top);
        end
        vectors++;
        if (int'($signed(dut.cnt)) != 9 || rng_out !== 16'h8000 || upd_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL start_cnt_rng cnt=%0d rng=%h ur=%b required 9/8000/1",
                     $signed(dut.cnt), rng_out, upd_ready);
        end
    endtask

    task automatic test_update_no_refill();
        int hs, cyc;
        bit done;
        establish_base();
        do_update(16'h8000, 16'h0000);
        vectors++;
        if (state_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL nop_valid_drop sv=%b required 0", state_valid);
        end
        run_until_valid(10, 0, hs, cyc, done);
        vectors++;
        if (!done || cyc != 1 || hs != 0) begin
            miscompares++;
            $display("[TB] FAIL nop_latency done=%b cycles=%0d hs=%0d required 1/1/0", done, cyc, hs);
        end
        vectors++;
        if (dif_top !== 16'h76E5 || rng_out !== 16'h8000 || dut.dif !== 32'h76E5D4FF) begin
            miscompares++;
            $display("[TB] FAIL nop_values dif=%h rng=%h required 76e5d4ff/8000", dut.dif, rng_out);
        end
    endtask

    task automatic test_update_refill(input int stall);
        int hs, cyc;
        bit done;
        establish_base();
        src.push_back(8'hAB); src.push_back(8'hCD);
        do_update(16'h0001, 16'h0000);
        run_until_valid(40, stall, hs, cyc, done);
        vectors++;
        if (!done || hs != 2 || cyc != 4 + stall) begin
            miscompares++;
            $display("[TB] FAIL refill_timing stall=%0d done=%b hs=%0d cycles=%0d required 1/2/%0d",
                     stall, done, hs, cyc, 4 + stall);
        end
        vectors++;
        if (dut.dif !== 32'hEA550CBF || dif_top !== 16'hEA55 || rng_out !== 16'h8000 ||
            int'($signed(dut.cnt)) != 10) begin
            miscompares++;
            $display("[TB] FAIL refill_values stall=%0d dif=%h rng=%h cnt=%0d required ea550cbf/8000/10",
                     stall, dut.dif, rng_out, $signed(dut.cnt));
        end
    endtask

    task automatic test_stream_end();
        int hs, cyc;
        bit done;
        establish_base();
        m_update(1, 0, 1'b1);
        src.push_back(8'hFF); src.push_back(8'hFF);
        stream_end = 1'b1;
        do_update(16'h0001, 16'h0000);
        run_until_valid(40, 0, hs, cyc, done);
        stream_end = 1'b0;
        vectors++;
        if (!done || hs != 0 || tail_bytes !== 8'd2) begin
            miscompares++;
            $display("[TB] FAIL stream_end_tail done=%b hs=%0d tail=%0d required 1/0/2", done, hs, tail_bytes);
        end
        vectors++;
        if (dut.dif !== m_dif[31:0] || int'($signed(dut.cnt)) != 10 || dif_top !== 16'hEA7F) begin
            miscompares++;
            $display("[TB] FAIL stream_end_values dif=%h cnt=%0d required %h/10",
                     dut.dif, $signed(dut.cnt), m_dif[31:0]);
        end
        src.delete();
    endtask

    task automatic test_reset_mid_refill();
        int hs, cyc;
        bit done;
        src.delete();
        src.push_back(8'h12); src.push_back(8'h34); src.push_back(8'h56);
        do_start();
        run_until_valid(1, 0, hs, cyc, done);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (rng_out !== 16'h8000 || dif_top !== 16'h7FFF || state_valid !== 1'b0 || byte_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_refill rng=%h dif_top=%h sv=%b br=%b required 8000/7fff/0/0",
                     rng_out, dif_top, state_valid, byte_ready);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        test_start_refill();
    endtask

    task automatic test_start_mid_refill();
        int hs, cyc;
        bit done;
        src.delete();
        src.push_back(8'h12); src.push_back(8'h34); src.push_back(8'h56);
        do_start();
        run_until_valid(1, 0, hs, cyc, done);
        // restart while a byte is being offered: it must not be consumed
        byte_valid = 1'b1;
        byte_data  = 8'h34;
        start      = 1'b1;
        #2;
        vectors++;
        if (byte_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL start_blocks_byte br=%b required 0", byte_ready);
        end
        @(posedge clk); #1;
        start = 1'b0;
        byte_valid = 1'b0;
        vectors++;
        if (rng_out !== 16'h8000 || dif_top !== 16'h7FFF || state_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL start_mid_refill rng=%h dif_top=%h sv=%b required 8000/7fff/0",
                     rng_out, dif_top, state_valid);
        end
        src.delete();
        src.push_back(8'h12); src.push_back(8'h34); src.push_back(8'h56);
        run_until_valid(20, 0, hs, cyc, done);
        vectors++;
        if (!done || dut.dif !== 32'h76E5D4FF || hs != 3) begin
            miscompares++;
            $display("[TB] FAIL restart_sequence done=%b dif=%h hs=%0d required 1/76e5d4ff/3", done, dut.dif, hs);
        end
        // start beats a simultaneous update
        upd_valid = 1'b1;
        upd_rng   = 16'h1234;
        upd_dif_sub = 16'h0001;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        upd_valid = 1'b0;
        vectors++;
        if (rng_out !== 16'h8000 || dif_top !== 16'h7FFF || state_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL start_over_update rng=%h dif_top=%h sv=%b required 8000/7fff/0",
                     rng_out, dif_top, state_valid);
        end
    endtask

    task automatic test_random();
        int hs, cyc, taken0, r, sub, st;
        bit done;
        logic [7:0] b;
        establish_base();
        m_taken = 0;
        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < 3; k++) begin
                b = 8'($urandom_range(0, 255));
                src.push_back(b);
                mq.push_back(int'(b));
            end
            r   = $urandom_range(1, 65535);
            sub = $urandom_range(0, int'(m_dif >> 16));
            st  = $urandom_range(0, 2);
            taken0 = m_taken;
            m_update(r, sub, 1'b0);
            do_update(16'(r), 16'(sub));
            run_until_valid(60, st, hs, cyc, done);
            vectors++;
            if (!done || rng_out !== m_rng[15:0] || dut.dif !== m_dif[31:0] ||
                int'($signed(dut.cnt)) != m_cnt || hs != m_taken - taken0) begin
                miscompares++;
                $display("[TB] FAIL random_update i=%0d rng=%h dif=%h cnt=%0d hs=%0d required %h/%h/%0d/%0d",
                         i, rng_out, dut.dif, $signed(dut.cnt), hs,
                         m_rng[15:0], m_dif[31:0], m_cnt, m_taken - taken0);
            end
        end
        // illegal zero range must still let the FSM progress
        for (int k = 0; k < 4; k++) src.push_back(8'($urandom_range(0, 255)));
        do_update(16'h0000, 16'h0000);
        run_until_valid(60, 0, hs, cyc, done);
        vectors++;
        if (!done) begin
            miscompares++;
            $display("[TB] FAIL zero_rng_progress sv=%b required 1", state_valid);
        end
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        upd_valid   = 1'b0;
        upd_rng     = 16'h0000;
        upd_dif_sub = 16'h0000;
        byte_valid  = 1'b0;
        byte_data   = 8'h00;
        stream_end  = 1'b0;
        m_taken     = 0;
        test_reset();
        test_start_refill();
        test_update_no_refill();
        test_update_refill(0);
        test_update_refill(5);
        test_stream_end();
        test_reset_mid_refill();
        test_start_mid_refill();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
